// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a small output FIFO.
// Each request is encoded in one combinational step, then queued together with
// its error flag. The head of the queue drives the output.

package instr_encoder_pkg;
  typedef logic [6:0] opcodes_t;

  localparam opcodes_t OPC_OP     = 7'b0110011;
  localparam opcodes_t OPC_OPIMM  = 7'b0010011;
  localparam opcodes_t OPC_LOAD   = 7'b0000011;
  localparam opcodes_t OPC_JALR   = 7'b1100111;
  localparam opcodes_t OPC_STORE  = 7'b0100011;
  localparam opcodes_t OPC_BRANCH = 7'b1100011;
  localparam opcodes_t OPC_LUI    = 7'b0110111;
  localparam opcodes_t OPC_AUIPC  = 7'b0010111;
  localparam opcodes_t OPC_JAL    = 7'b1101111;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
endpackage

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  opcodes_t    in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_func3,
  input  logic        in_f7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic signed [31:0] imm_s;
  logic               fits_s12;
  logic               fits_b13;
  logic               fits_j21;
  logic               is_shift;
  logic [31:0]        enc_instr;
  logic               enc_err;

  logic [32:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push;
  logic               pop;

  assign imm_s    = $signed(in_imm);
  assign fits_s12 = (imm_s >= -32'sd2048)    && (imm_s <= 32'sd2047);
  // Branch and jump offsets are half-word aligned, so the upper bound is even.
  assign fits_b13 = (imm_s >= -32'sd4096)    && (imm_s <= 32'sd4094);
  assign fits_j21 = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574);
  assign is_shift = (in_func3 == 3'b001) || (in_func3 == 3'b101);

  // Field packing per instruction format; the word is still produced on error.
  always_comb begin
    enc_instr = INSTR_NOP;
    enc_err   = 1'b0;
    case (in_opcode)
      OPC_OP: begin
        enc_instr = {1'b0, in_f7, 5'b0, in_rs2, in_rs1, in_func3, in_rd, in_opcode};
      end
      OPC_OPIMM: begin
        if (is_shift) begin
          enc_instr = {1'b0, in_f7, 5'b0, in_imm[4:0], in_rs1, in_func3, in_rd, in_opcode};
          enc_err   = (imm_s < 32'sd0) || (imm_s > 32'sd31);
        end else begin
          enc_instr = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
          enc_err   = !fits_s12;
        end
      end
      OPC_LOAD: begin
        enc_instr = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
        enc_err   = !fits_s12;
      end
      OPC_JALR: begin
        enc_instr = {in_imm[11:0], in_rs1, in_func3, in_rd, in_opcode};
        enc_err   = !fits_s12 || (in_func3 != 3'b000);
      end
      OPC_STORE: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_func3, in_imm[4:0], in_opcode};
        enc_err   = !fits_s12;
      end
      OPC_BRANCH: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_func3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = !fits_b13 || in_imm[0];
      end
      OPC_LUI, OPC_AUIPC: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = (in_imm[11:0] != 12'h000);
      end
      OPC_JAL: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = !fits_j21 || in_imm[0];
      end
      default: begin
        enc_instr = INSTR_NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

  // A full FIFO refuses pushes even if the head leaves on the same edge.
  assign in_ready  = (count != CNT_W'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_instr = out_valid ? mem[rd_ptr][31:0] : 32'h0;
  assign out_err   = out_valid ? mem[rd_ptr][32]   : 1'b0;

  // Storage needs no reset: the empty state masks its contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {enc_err, enc_instr};
  end

  // Pointers, occupancy and the saturating error counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (push && enc_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors, back-pressure,
// randomized traffic against a queue-based reference, and mid-run reset.

module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  opcodes_t    in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_func3 = '0;
  logic        in_f7 = 1'b0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;
  int exp_err_cnt = 0;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_f7(in_f7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference encoder built from field positions with integer arithmetic.
  function automatic void ref_encode(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [2:0] f3, input logic f7,
                                     input logic [31:0] imm,
                                     output logic [31:0] instr, output logic err);
    int s;
    bit [31:0] u, base_r, base_i;
    s = $signed(imm);
    u = imm;
    base_r = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
    base_i = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | 32'(op);
    instr = 32'h13;
    err = 1'b0;
    if (op == 7'b0110011) begin
      instr = (32'(f7) << 30) | base_r;
    end else if (op == 7'b0010011 && (f3 == 3'd1 || f3 == 3'd5)) begin
      instr = (32'(f7) << 30) | ((u & 32'h1F) << 20) | base_i;
      err = (s < 0) || (s > 31);
    end else if (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) begin
      instr = ((u & 32'hFFF) << 20) | base_i;
      err = (s < -2048) || (s > 2047) || (op == 7'b1100111 && f3 != 3'd0);
    end else if (op == 7'b0100011) begin
      instr = (((u >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) |
              (32'(f3) << 12) | ((u & 32'h1F) << 7) | 32'(op);
      err = (s < -2048) || (s > 2047);
    end else if (op == 7'b1100011) begin
      instr = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (32'(rs2) << 20) |
              (32'(rs1) << 15) | (32'(f3) << 12) | (((u >> 1) & 32'hF) << 8) |
              (((u >> 11) & 1) << 7) | 32'(op);
      err = (s < -4096) || (s > 4094) || (s % 2 != 0);
    end else if (op == 7'b0110111 || op == 7'b0010111) begin
      instr = (u & 32'hFFFFF000) | (32'(rd) << 7) | 32'(op);
      err = (u & 32'hFFF) != 0;
    end else if (op == 7'b1101111) begin
      instr = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20) |
              (((u >> 12) & 32'hFF) << 12) | (32'(rd) << 7) | 32'(op);
      err = (s < -1048576) || (s > 1048574) || (s % 2 != 0);
    end else begin
      instr = 32'h13;
      err = 1'b1;
    end
  endfunction

  // Present one request for exactly one edge; returns #1 after that edge.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                      input logic [31:0] imm);
    @(negedge clk);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_f7 = f7; in_imm = imm; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 || err_count !== 16'h0) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b instr=%h err=%b cnt=%h, want 0/0/0/0",
               out_valid, out_instr, out_err, err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [10];
    vecs[0] = '{7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF, 32'hFFF10093, 1'b0};
    vecs[1] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'h0,        32'h402081B3, 1'b0};
    vecs[2] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048,     32'h001000EF, 1'b0};
    vecs[3] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8,        32'h00000463, 1'b0};
    vecs[4] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7,        32'h00000363, 1'b1};
    vecs[5] = '{7'h7F, 5'd4, 5'd5, 5'd6, 3'd2, 1'b1, 32'd100,      32'h00000013, 1'b1};
    vecs[6] = '{7'h13, 5'd1, 5'd1, 5'd0, 3'd1, 1'b0, 32'd33,       32'h00109093, 1'b1};
    vecs[7] = '{7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 32'h12345037, 1'b0};
    vecs[8] = '{7'h67, 5'd0, 5'd0, 5'd0, 3'd1, 1'b0, 32'h0,        32'h00001067, 1'b1};
    vecs[9] = '{7'h23, 5'd0, 5'd2, 5'd1, 3'd2, 1'b0, 32'hFFFFFFFC, 32'hFE112E23, 1'b0};
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].f3, vecs[i].f7, vecs[i].imm);
      if (vecs[i].err) exp_err_cnt++;
      checks++;
      if (out_valid !== 1'b1 || out_instr !== vecs[i].instr || out_err !== vecs[i].err) begin
        failures++;
        $display("FAIL directed[%0d]: got valid=%b instr=%h err=%b, want 1 %h %b",
                 i, out_valid, out_instr, out_err, vecs[i].instr, vecs[i].err);
      end
      checks++;
      if (err_count !== 16'(exp_err_cnt)) begin
        failures++;
        $display("FAIL directed_errcnt[%0d]: got %0d want %0d", i, err_count, exp_err_cnt);
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
      failures++;
      $display("FAIL directed_drain: got valid=%b instr=%h want 0 0", out_valid, out_instr);
    end
  endtask

  task automatic test_back_to_back_full();
    logic [31:0] exp_i [5];
    logic        exp_e [5];
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ref_encode(OPC_OPIMM, 5'(i + 1), 5'(i), 5'd0, 3'd0, 1'b0, 32'(i * 4), exp_i[i], exp_e[i]);
      send(OPC_OPIMM, 5'(i + 1), 5'(i), 5'd0, 3'd0, 1'b0, 32'(i * 4));
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== exp_i[0]) begin
      failures++;
      $display("FAIL full_after4: got ready=%b valid=%b instr=%h want 0 1 %h",
               in_ready, out_valid, out_instr, exp_i[0]);
    end
    ref_encode(OPC_OP, 5'd5, 5'd6, 5'd7, 3'd4, 1'b1, 32'h0, exp_i[4], exp_e[4]);
    @(negedge clk);
    in_opcode = OPC_OP; in_rd = 5'd5; in_rs1 = 5'd6; in_rs2 = 5'd7;
    in_func3 = 3'd4; in_f7 = 1'b1; in_imm = 32'h0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_instr !== exp_i[0]) begin
      failures++;
      $display("FAIL full_held: got ready=%b instr=%h want 0 %h", in_ready, out_instr, exp_i[0]);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_instr !== exp_i[1]) begin
      failures++;
      $display("FAIL full_first_pop: got ready=%b instr=%h want 1 %h", in_ready, out_instr, exp_i[1]);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 2; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_instr !== exp_i[i] || out_err !== exp_e[i]) begin
        failures++;
        $display("FAIL full_order[%0d]: got valid=%b instr=%h err=%b want 1 %h %b",
                 i, out_valid, out_instr, out_err, exp_i[i], exp_e[i]);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_empty: got valid=%b want 0", out_valid);
    end
  endtask

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 4))
      0: v = int'($urandom_range(0, 80)) - 40;
      1: v = int'($urandom_range(0, 10000)) - 5000;
      2: v = int'($urandom_range(0, 2200000)) - 1100000;
      3: v = int'($urandom & 32'hFFFFF000);
      default: v = int'($urandom);
    endcase
    return 32'(v);
  endfunction

  task automatic test_random();
    logic [32:0] q [$];
    logic [6:0]  ops [9];
    logic [31:0] ri;
    logic        re;
    logic        push, pop;
    ops = '{OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL};
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_opcode = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_func3 = 3'($urandom); in_f7 = 1'($urandom); in_imm = rand_imm();
      #1;
      checks++;
      if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH)) begin
        failures++;
        $display("FAIL rand_flags[%0d]: got valid=%b ready=%b, occupancy %0d", cyc,
                 out_valid, in_ready, q.size());
      end
      checks++;
      if (q.size() != 0) begin
        if (out_instr !== q[0][31:0] || out_err !== q[0][32]) begin
          failures++;
          $display("FAIL rand_head[%0d]: got instr=%h err=%b want %h %b", cyc,
                   out_instr, out_err, q[0][31:0], q[0][32]);
        end
      end else if (out_instr !== 32'h0 || out_err !== 1'b0) begin
        failures++;
        $display("FAIL rand_empty[%0d]: got instr=%h err=%b want 0 0", cyc, out_instr, out_err);
      end
      checks++;
      if (err_count !== 16'(exp_err_cnt)) begin
        failures++;
        $display("FAIL rand_errcnt[%0d]: got %0d want %0d", cyc, err_count, exp_err_cnt);
      end
      ref_encode(in_opcode, in_rd, in_rs1, in_rs2, in_func3, in_f7, in_imm, ri, re);
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() != 0);
      @(posedge clk);
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back({re, ri});
        if (re && exp_err_cnt < 65535) exp_err_cnt++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || err_count !== 16'(exp_err_cnt)) begin
      failures++;
      $display("FAIL rand_drain: got valid=%b cnt=%0d want 0 %0d", out_valid, err_count, exp_err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    out_ready = 1'b0;
    send(OPC_OPIMM, 5'd1, 5'd2, 5'd0, 3'd0, 1'b0, 32'd5);
    send(OPC_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd7);
    exp_err_cnt++;
    send(OPC_LUI, 5'd9, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE000);
    #2;
    checks++;
    if (out_valid !== 1'b1 || err_count !== 16'(exp_err_cnt)) begin
      failures++;
      $display("FAIL mid_before: got valid=%b cnt=%0d want 1 %0d", out_valid, err_count, exp_err_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0 || err_count !== 16'h0) begin
      failures++;
      $display("FAIL mid_async: got valid=%b instr=%h err=%b cnt=%h want all 0",
               out_valid, out_instr, out_err, err_count);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_err_cnt = 0;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || err_count !== 16'h0) begin
      failures++;
      $display("FAIL mid_release: got ready=%b cnt=%0d want 1 0", in_ready, err_count);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
        failures++;
        $display("FAIL mid_stale[%0d]: got valid=%b instr=%h want 0 0", i, out_valid, out_instr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back_full();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the output FIFO entry count (power of two, at least 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an encode request is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the request is accepted on this edge.
REQ-006 The block SHALL have port in_opcode, input, 7 bits, of type opcodes_t.
REQ-007 The block SHALL have ports in_rd, in_rs1 and in_rs2, inputs, 5 bits each: register indices.
REQ-008 The block SHALL have port in_func3, input, 3 bits: the funct3 field.
REQ-009 The block SHALL have port in_f7, input, 1 bit: the value placed in instruction bit 30.
REQ-010 The block SHALL have port in_imm, input, 32 bits: signed immediate in bytes; for U-type it is the full 32-bit value.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the FIFO head is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head.
REQ-013 The block SHALL have port out_instr, output, 32 bits: the encoded RV32I word at the FIFO head.
REQ-014 The block SHALL have port out_err, output, 1 bit: the head entry violated an encoding rule.
REQ-015 The block SHALL have port err_count, output, 16 bits: saturating count of accepted erroneous requests.

Function
REQ-016 Accept: the block SHALL accept a request when in_valid and in_ready are both high; in_ready = FIFO not full, independent of out_ready (no push while full, even on a simultaneous pop).
REQ-017 On accept, the block SHALL encode combinationally and write {instr, err} into the FIFO tail; the entry appears on out_instr and out_valid in the cycle after the accepting edge (latency 1).
REQ-018 Pop: the block SHALL remove the head when out_valid and out_ready are both high; push and pop on the same edge (not full) SHALL leave occupancy unchanged.
REQ-019 Entries SHALL leave the FIFO in strict acceptance order; pointers wrap modulo FIFO_DEPTH.
REQ-020 When empty, the block SHALL drive out_valid=0, out_instr=0 and out_err=0.
REQ-021 OP (0110011) SHALL encode {0,f7,00000,rs2,rs1,func3,rd,opcode}; in_imm is ignored and no error is raised.
REQ-022 OPIMM (0010011), LOAD (0000011) and JALR (1100111) SHALL encode imm[11:0] in bits [31:20], then rs1, func3, rd, opcode; err is raised if imm is outside [-2048, 2047].
REQ-023 OPIMM with func3 001 or 101 SHALL place {0,f7,00000,imm[4:0]} in bits [31:20]; err is raised if imm is outside [0, 31].
REQ-024 JALR SHALL raise err if func3 is not 000.
REQ-025 STORE (0100011) SHALL encode {imm[11:5],rs2,rs1,func3,imm[4:0],opcode}; err is raised if imm is outside [-2048, 2047].
REQ-026 BRANCH (1100011) SHALL encode {imm[12],imm[10:5],rs2,rs1,func3,imm[4:1],imm[11],opcode}; err is raised if imm is outside [-4096, 4094] or imm[0]=1.
REQ-027 LUI (0110111) and AUIPC (0010111) SHALL encode {imm[31:12],rd,opcode}; err is raised if imm[11:0] is not zero.
REQ-028 JAL (1101111) SHALL encode {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}; err is raised if imm is outside [-1048576, 1048574] or imm[0]=1.
REQ-029 On err, the block SHALL still emit the truncated encoding for known opcodes.
REQ-030 For an unknown opcode, the block SHALL emit out_instr=32'h00000013 with err=1.
REQ-031 err_count SHALL increment by 1 on each accepted request whose err=1, saturating at 16'hFFFF.

Reset
REQ-032 While rst_n=0, the block SHALL immediately (asynchronously) empty the FIFO and drive out_valid=0, out_instr=0, out_err=0 and err_count=0.
REQ-033 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-034 Reset mid-operation SHALL discard all queued entries; no stale entry SHALL appear after release.

Verification
REQ-035 The bench SHALL cover: OPIMM rd=1 rs1=2 f3=000 imm=-1 -> out_instr=0xFFF10093 and out_err=0 one cycle after accept.
REQ-036 The bench SHALL cover: OP f7=1 f3=000 rd=3 rs1=1 rs2=2 -> 0x402081B3; and JAL rd=1 imm=2048 -> 0x001000EF.
REQ-037 The bench SHALL cover: BRANCH rs1=rs2=0 f3=000 imm=8 -> 0x00000463 with err=0; the same request with imm=7 -> err=1 and err_count incremented by 1.
REQ-038 The bench SHALL cover: with out_ready=0, four accepts -> in_ready=0 and a fifth request is held; then out_ready=1 -> four words out in order, and in_ready rises after the first pop.
REQ-039 The bench SHALL cover: in_opcode=7'h7F -> out_instr=0x00000013 with out_err=1.
REQ-040 The bench SHALL cover: rst_n pulsed low with 3 entries queued -> out_valid=0 at once; after release, err_count=0, in_ready=1, and no old entry appears.
